// File: rtl/if2_inst_queue.sv
`default_nettype none
// ============================================================================
// Module   : if2_inst_queue
// Purpose  : Second instruction-fetch stage. It captures the 1-cycle-latency
//            instruction SRAM read data for the PC issued by IF1. It buffers
//            up to DEPTH fetched instructions so that ID back-pressure never
//            loses an SRAM response. PC/instruction pairs are presented to ID
//            through a valid/ready handshake, and a branch flush kills
//            everything held or in flight.
//
// Parameters:
//   DEPTH    queue entries (power of two, >= 2)
//   PC_WD    PC width
//   INST_WD  instruction width
//
// Ports:
//   clk              in   clock, all state changes on posedge
//   rst_n            in   asynchronous active-low reset
//   flush            in   branch redirect, kills held and in-flight fetches
//   in_valid         in   IF1 issued an SRAM read for in_pc this cycle
//   in_pc            in   PC of the issued read
//   in_ready         out  IF2 can accept the issued read
//   inst_sram_rdata  in   SRAM data, valid the cycle after issue only
//   out_valid        out  instruction available to ID
//   out_pc           out  PC of head instruction (0 when no valid output)
//   out_inst         out  head instruction (0 when no valid output)
//   out_ready        in   ID accepts the head instruction
//   out_br_hint      out  head is JAL/JALR/BRANCH (predecode build only)
//   occupancy        out  number of queue entries held (debug/perf)
//
// Build option:
//   IF2_PREDECODE_EN  when defined, each queue entry carries a predecoded
//                     control-transfer flag that drives out_br_hint. When it
//                     is undefined, out_br_hint is tied low and no flag
//                     storage exists.
//
// Revision : 1.0 - initial release
// ============================================================================
module if2_inst_queue #(
  parameter int DEPTH   = 4,
  parameter int PC_WD   = 32,
  parameter int INST_WD = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     in_valid,
  input  logic [PC_WD-1:0]         in_pc,
  output logic                     in_ready,
  input  logic [INST_WD-1:0]       inst_sram_rdata,
  output logic                     out_valid,
  output logic [PC_WD-1:0]         out_pc,
  output logic [INST_WD-1:0]       out_inst,
  input  logic                     out_ready,
  output logic                     out_br_hint,
  output logic [$clog2(DEPTH):0]   occupancy
);

  // Pointer width, count width (must hold the value DEPTH), and one extra
  // bit for the in_ready level arithmetic so count + s_valid never wraps.
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int LW = CW + 1;

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic               s_valid_q, s_valid_d;
  logic [PC_WD-1:0]   s_pc_q,    s_pc_d;
  logic [CW-1:0]      count_q,   count_d;
  logic [AW-1:0]      rd_ptr_q,  rd_ptr_d;
  logic [AW-1:0]      wr_ptr_q,  wr_ptr_d;

  // Queue storage. Contents are only ever read when count_q says an entry is
  // live, so the arrays need no reset.
  logic [PC_WD-1:0]   pc_mem_q   [DEPTH];
  logic [INST_WD-1:0] inst_mem_q [DEPTH];

  // --------------------------------------------------------------------------
  // Combinational datapath
  // --------------------------------------------------------------------------
  logic               w_q_nonempty;
  logic               w_pop;
  logic               w_pop_q;
  logic               w_push;
  logic               w_accept;
  logic [LW-1:0]      w_level;
  logic [PC_WD-1:0]   w_head_pc;
  logic [INST_WD-1:0] w_head_inst;

  assign w_q_nonempty = (count_q != '0);

  // The queue head always has priority. Only when the queue is empty does the
  // SRAM response bypass straight to ID, giving zero added latency.
  assign w_head_pc   = w_q_nonempty ? pc_mem_q[rd_ptr_q]   : s_pc_q;
  assign w_head_inst = w_q_nonempty ? inst_mem_q[rd_ptr_q] : inst_sram_rdata;

  assign out_valid = !flush && (w_q_nonempty || s_valid_q);

  // A bubble is driven as all zeros so that ID never sees stale data.
  assign out_pc   = out_valid ? w_head_pc   : '0;
  assign out_inst = out_valid ? w_head_inst : '0;

  // out_valid already contains !flush, so a flush can never pop.
  assign w_pop   = out_valid && out_ready;
  assign w_pop_q = w_pop && w_q_nonempty;

  // The arriving response is stored unless ID takes it directly through the
  // bypass (which happens only when the queue is empty and ID is ready).
  assign w_push = s_valid_q && !flush && !(!w_q_nonempty && out_ready);

  // Level seen by the next response: everything held, plus the response
  // arriving now, minus what ID takes this cycle. Accepting a new read only
  // while this is below DEPTH reserves a slot for it before it arrives, so
  // the queue can never overflow.
  assign w_level  = LW'(count_q) + LW'(s_valid_q) - LW'(w_pop);
  assign in_ready = !flush && (w_level < LW'(DEPTH));

  assign w_accept = in_valid && in_ready;

  assign occupancy = count_q;

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    s_valid_d = w_accept;
    s_pc_d    = s_pc_q;
    count_d   = count_q;
    rd_ptr_d  = rd_ptr_q;
    wr_ptr_d  = wr_ptr_q;

    if (w_accept) begin
      s_pc_d = in_pc;
    end

    if (flush) begin
      // Flush discards both the queue and the response arriving this cycle.
      count_d  = '0;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
    end else begin
      // Pointers wrap naturally because DEPTH is a power of two.
      if (w_push) begin
        wr_ptr_d = wr_ptr_q + AW'(1);
      end
      if (w_pop_q) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
      end
      count_d = count_q + CW'(w_push) - CW'(w_pop_q);
    end
  end

  // --------------------------------------------------------------------------
  // Control registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_valid_q <= 1'b0;
      s_pc_q    <= '0;
      count_q   <= '0;
      rd_ptr_q  <= '0;
      wr_ptr_q  <= '0;
    end else begin
      s_valid_q <= s_valid_d;
      s_pc_q    <= s_pc_d;
      count_q   <= count_d;
      rd_ptr_q  <= rd_ptr_d;
      wr_ptr_q  <= wr_ptr_d;
    end
  end

  // --------------------------------------------------------------------------
  // Queue storage write port
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (w_push) begin
      pc_mem_q[wr_ptr_q]   <= s_pc_q;
      inst_mem_q[wr_ptr_q] <= inst_sram_rdata;
    end
  end

  // --------------------------------------------------------------------------
  // Branch predecode hint
  // --------------------------------------------------------------------------
`ifdef IF2_PREDECODE_EN
  // RISC-V major opcodes for JAL, JALR and conditional BRANCH.
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  logic w_rdata_cti;
  logic w_head_hint;
  logic hint_mem_q [DEPTH];

  assign w_rdata_cti = (inst_sram_rdata[6:0] == OP_JAL)  ||
                       (inst_sram_rdata[6:0] == OP_JALR) ||
                       (inst_sram_rdata[6:0] == OP_BRANCH);

  // The flag is decoded once on arrival and stored with the entry, so the
  // queued path and the bypass path both deliver it with no added latency.
  always_ff @(posedge clk) begin
    if (w_push) begin
      hint_mem_q[wr_ptr_q] <= w_rdata_cti;
    end
  end

  assign w_head_hint = w_q_nonempty ? hint_mem_q[rd_ptr_q] : w_rdata_cti;
  assign out_br_hint = out_valid && w_head_hint;
`else
  assign out_br_hint = 1'b0;
`endif

endmodule
`default_nettype wire

// File: doc/if2_inst_queue.md
Name: if2_inst_queue

Overview:
- Parametrised second fetch stage. It sits between IF1, which issues the PC to the instruction SRAM, and ID.
- It captures the 1-cycle-latency SRAM read data for the PC issued by IF1.
- It buffers up to DEPTH fetched instructions, so ID back-pressure never loses an SRAM response.
- It presents PC/instruction pairs to ID through a valid/ready handshake, and supports a branch flush.

Parameters:
- DEPTH, 4, instruction queue entries; power of two, >=2.
- PC_WD, 32, PC width.
- INST_WD, 32, instruction width.

Ports:
- clk  in  1  clock; all state changes on posedge.
- rst_n  in  1  reset; asynchronous and active-low.
- flush  in  1  branch redirect; kills all held and in-flight fetches.
- in_valid  in  1  IF1 has issued an SRAM read for in_pc this cycle.
- in_pc  in  PC_WD  PC of the issued read.
- in_ready  out  1  IF2 can accept the issued read; IF1 issues only when high.
- inst_sram_rdata  in  INST_WD  SRAM data; valid the cycle after issue only.
- out_valid  out  1  instruction available to ID.
- out_pc  out  PC_WD  PC of head instruction.
- out_inst  out  INST_WD  head instruction.
- out_ready  in  1  ID accepts (i.e. ID not stalled).
- out_br_hint  out  1  head is a control-transfer instruction (see Optional Feature).
- occupancy  out  clog2(DEPTH)+1  queue entry count, for debug/perf.

Behaviour:
- Reset (rst_n low, asynchronous):
  - s_valid=0, s_pc=0; queue count=0, rd_ptr=0, wr_ptr=0.
  - out_valid=0, out_pc=0, out_inst=0, out_br_hint=0, occupancy=0, in_ready=1.
  - Reset asserted mid-operation discards everything immediately.
- Stage register:
  - On posedge, s_valid <= in_valid & in_ready & !flush; s_pc <= in_pc when accepted.
  - When s_valid=1, inst_sram_rdata carries the instruction for s_pc in that cycle only.
- pop = out_valid & out_ready & !flush.
- Output / bypass:
  - When count>0: head = queue[rd_ptr].
  - When count=0 and s_valid=1: head = {s_pc, inst_sram_rdata}, bypass path with zero added latency.
  - out_valid = !flush & (count>0 | s_valid).
  - When out_valid=0: out_pc=0, out_inst=0, out_br_hint=0 (bubble is all zeros).
- Push: s_valid & !flush & !(count==0 & out_ready). The stage data enters the queue at wr_ptr and wr_ptr increments, wrapping modulo DEPTH.
- Pop with count>0: rd_ptr increments (wraps).
- Count: next_count = count + push - (pop & count>0). Simultaneous push and pop keeps count unchanged.
- in_ready = !flush & ((count + s_valid - pop) < DEPTH). This guarantees that every issued read has a slot on arrival, so the queue never overflows.
- Full case: count==DEPTH with no pop gives in_ready=0. A pop in the same cycle raises in_ready combinationally.
- Empty case: count==0 and s_valid=0 gives out_valid=0.
- flush:
  - Same cycle: out_valid=0, in_ready=0, no push.
  - Next edge: count=0, rd_ptr=wr_ptr=0, s_valid=0. The SRAM response arriving in the flush cycle is discarded.
  - Cycle after flush: in_ready=1.
- Flush while full, or flush with pop, is handled the same way: flush wins.
- Throughput: one instruction per cycle sustained when out_ready is held high. Latency from IF1 issue to out_valid is 1 cycle via bypass.

Optional Feature:
- Macro IF2_PREDECODE_EN.
- Defined:
  - out_br_hint = out_valid & (out_inst[6:0] is 1101111 JAL, 1100111 JALR, or 1100011 BRANCH).
  - The hint is computed from whichever source is the head: queue or bypass.
  - No added latency; one extra flag bit per queue entry is permitted.
- Not defined: out_br_hint tied to 0; no extra storage.

Test Plan:
- Reset: hold rst_n=0 with in_valid=1 -> out_valid=0, in_ready=1, occupancy=0; release reset -> first issue of PC 0x80000000 with rdata 0x00000013 the next cycle gives out_valid=1, out_pc=0x80000000, out_inst=0x00000013 the same cycle (bypass), occupancy stays 0.
- Streaming: issue PCs 0x100, 0x104, 0x108 on consecutive cycles with out_ready=1 -> three outputs on consecutive cycles, in order, occupancy always 0.
- Back-pressure/full (DEPTH=4): out_ready=0, issue while in_ready=1 -> exactly 4 instructions accepted, occupancy=4, in_ready=0; then out_ready=1 -> 4 instructions drain in order, in_ready rises the same cycle as the first pop.
- Flush: queue holding 3 entries plus one read in flight, assert flush 1 cycle -> out_valid=0 during flush, occupancy=0 next cycle, the in-flight rdata 0xDEADBEEF never appears at the output, the next issue of PC 0x200 is output correctly.
- Wrap-around: run 10 push/pop cycles with out_ready toggling 1,0,1,0 -> ordering preserved across pointer wrap, no drop or duplicate (checked against a scoreboard).
- Predecode (IF2_PREDECODE_EN defined): rdata 0x0000006F gives out_br_hint=1; 0x00000013 gives 0; 0x00008067 gives 1. With the macro undefined, out_br_hint=0 for all three.
